// File: rtl/sw_conditioner.sv
// sw_conditioner: synchronise, debounce and pace the two board switches for the 2-bit state machine.
// Optional: define SW_CHANGE_STEP_EN to fire step on every sw_changed and restart the step period.
module sw_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 500000,
  parameter int TICK_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sw_raw,
  output logic [1:0] sw_stable,
  output logic       sw_valid,
  output logic       sw_changed,
  output logic       step
);
  localparam int SW = 2 * SYNC_STAGES;
  localparam int DW = $clog2(DEB_CYCLES);
  localparam int TW = $clog2(TICK_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  typedef enum logic [1:0] {INIT, STABLE, SETTLE} state_t;
  state_t r_state;
  logic [SW-1:0] r_sync;
  logic [1:0] r_cand, r_stable;
  logic [DW-1:0] r_cnt;
  logic [TW-1:0] r_tick;
  logic r_valid, r_changed, r_step;
  logic [1:0] w_sync;
  logic w_same, w_last, w_chg, w_wrap, w_restart;
  always_comb begin
    w_sync = r_sync[SW-1 -: 2];
    w_same = w_sync == r_cand;
    w_last = r_cnt == DEB_LAST;
    w_chg = (r_state == SETTLE) && w_same && w_last && (r_cand != r_stable);
    w_wrap = r_tick == TICK_LAST;
`ifdef SW_CHANGE_STEP_EN
    w_restart = w_wrap | w_chg;
`else
    w_restart = w_wrap;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else r_sync <= {r_sync[SW-3:0], sw_raw};
  end
  // The 2-bit vector is debounced as one value: any change restarts the settle count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
      r_cand <= '0;
      r_cnt <= '0;
      r_stable <= '0;
      r_valid <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_changed <= w_chg;
      case (r_state)
        INIT:
          if (!w_same) begin
            r_cand <= w_sync;
            r_cnt <= '0;
          end else if (w_last) begin
            r_stable <= r_cand;
            r_valid <= 1'b1;
            r_state <= STABLE;
          end else r_cnt <= r_cnt + 1'b1;
        STABLE:
          if (w_sync != r_stable) begin
            r_cand <= w_sync;
            r_cnt <= '0;
            r_state <= SETTLE;
          end
        SETTLE:
          if (!w_same) begin
            r_cand <= w_sync;
            r_cnt <= '0;
          end else if (w_last) begin
            r_stable <= r_cand;
            r_state <= STABLE;
          end else r_cnt <= r_cnt + 1'b1;
        default: r_state <= INIT;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst || !r_valid) begin
      r_tick <= '0;
      r_step <= 1'b0;
    end else begin
      r_tick <= w_restart ? '0 : r_tick + 1'b1;
      r_step <= w_restart;
    end
  end
  assign sw_stable = r_stable;
  assign sw_valid = r_valid;
  assign sw_changed = r_changed;
  assign step = r_step;
endmodule

// File: tb/tb_sw_conditioner.sv
// tb_sw_conditioner: directed scenarios plus random switch traffic against a run-length reference model.
module tb_sw_conditioner;
  localparam int S = 2, D = 4, T = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] sw_raw = 2'b00;
  logic [1:0] sw_stable;
  logic sw_valid, sw_changed, step;
  int checks = 0, failures = 0;
  int n_chg = 0, n_step = 0;
  logic [1:0] m_pipe[$];
  logic [1:0] m_prev, m_stable;
  bit m_valid, m_changed, m_step;
  int m_run, m_anchor, edge_n;
  sw_conditioner #(.SYNC_STAGES(S), .DEB_CYCLES(D), .TICK_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .sw_raw(sw_raw), .sw_stable(sw_stable),
    .sw_valid(sw_valid), .sw_changed(sw_changed), .step(step)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask
  // A value is accepted once the FSM has seen it on D+1 consecutive samples.
  task automatic model();
    logic [1:0] x;
    bit was_valid;
    m_changed = 0;
    m_step = 0;
    if (rst) begin
      m_pipe.delete();
      repeat (S) m_pipe.push_back(2'b00);
      m_prev = 2'b00;
      m_run = 1;
      m_stable = 2'b00;
      m_valid = 0;
      m_anchor = 0;
      edge_n = 0;
      return;
    end
    edge_n++;
    was_valid = m_valid;
    x = m_pipe.pop_front();
    m_pipe.push_back(sw_raw);
    m_run = (x == m_prev) ? m_run + 1 : 1;
    m_prev = x;
    if (m_run == D + 1) begin
      m_changed = m_valid && (x != m_stable);
      if (!m_valid) m_anchor = edge_n;
      m_stable = x;
      m_valid = 1;
    end
    if (was_valid && ((edge_n - m_anchor) % T == 0)) m_step = 1;
`ifdef SW_CHANGE_STEP_EN
    if (m_changed) begin
      m_step = 1;
      m_anchor = edge_n;
    end
`endif
  endtask
  task automatic cyc(input logic [1:0] raw, input logic r);
    @(negedge clk);
    sw_raw = raw;
    rst = r;
    @(posedge clk);
    model();
    #1;
    chk("stable", {30'd0, sw_stable}, {30'd0, m_stable});
    chk("valid", {31'd0, sw_valid}, {31'd0, m_valid});
    chk("changed", {31'd0, sw_changed}, {31'd0, m_changed});
    chk("step", {31'd0, step}, {31'd0, m_step});
    n_chg += int'(sw_changed);
    n_step += int'(step);
  endtask
  initial begin
    int at, last_step, chg_at, hold;
    logic [1:0] v;
    rst = 1'b1;
    model();
    repeat (3) cyc(2'b11, 1'b1);
    n_chg = 0;
    n_step = 0;
    repeat (7) cyc(2'b11, 1'b0);
    chk("t1_valid", {31'd0, sw_valid}, 1);
    chk("t1_stable", {30'd0, sw_stable}, 3);
    chk("t1_nochg", n_chg, 0);
    repeat (10) cyc(2'b00, 1'b0);
    n_chg = 0;
    at = -1;
    for (int i = 0; i < 20; i++) cyc(((i / 2) % 2) != 0 ? 2'b01 : 2'b00, 1'b0);
    chk("t2_bounce_stable", {30'd0, sw_stable}, 0);
    for (int k = 1; k <= 10; k++) begin
      cyc(2'b01, 1'b0);
      if (sw_changed && at < 0) at = k + 1;
    end
    chk("t2_latency", at, 6);
    chk("t2_pulses", n_chg, 1);
    chk("t2_stable", {30'd0, sw_stable}, 1);
    repeat (10) cyc(2'b10, 1'b0);
    n_chg = 0;
    repeat (3) cyc(2'b11, 1'b0);
    repeat (10) cyc(2'b10, 1'b0);
    chk("t3_nochg", n_chg, 0);
    chk("t3_stable", {30'd0, sw_stable}, 2);
    n_step = 0;
    repeat (40) cyc(2'b10, 1'b0);
    chk("t4_steps", n_step, 5);
    repeat (10) cyc(2'b00, 1'b0);
    n_chg = 0;
    repeat (4) cyc(2'b11, 1'b0);
    cyc(2'b11, 1'b1);
    chk("t5_rst_valid", {31'd0, sw_valid}, 0);
    chk("t5_rst_stable", {30'd0, sw_stable}, 0);
    repeat (10) cyc(2'b11, 1'b0);
    chk("t5_nochg", n_chg, 0);
    chk("t5_recap", {30'd0, sw_stable}, 3);
    last_step = -1;
    chg_at = -1;
    for (int i = 0; i < 45; i++) begin
      cyc(i < 13 ? 2'b00 : 2'b01, 1'b0);
      if (sw_changed) begin
        chg_at = i;
`ifdef SW_CHANGE_STEP_EN
        chk("t6_coinc", {31'd0, step}, 1);
`endif
      end
      if (step) begin
`ifdef SW_CHANGE_STEP_EN
        if (last_step >= 0 && i != chg_at) chk("t6_gap", i - last_step, T);
`else
        if (last_step >= 0) chk("t6_gap", i - last_step, T);
`endif
        last_step = i;
      end
    end
    chk("t6_stable", {30'd0, sw_stable}, 1);
    for (int n = 0; n < 3000; ) begin
      v = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 8);
      if ($urandom_range(0, 39) == 0) begin
        cyc(v, 1'b1);
        n++;
      end
      for (int h = 0; h < hold; h++) cyc(v, 1'b0);
      n += hold;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
